// File: rtl/flash_score_seq.sv
// rtl/flash_score_seq.sv - moves a multi-byte score record to/from flash, one bridge transaction per byte
module flash_score_seq #(
    parameter int         NBYTES    = 4,
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         TIMEOUT   = 1024
) (
    input  logic                CLK_50MHZ,
    input  logic                RST,
    input  logic                cmd_save,
    input  logic                cmd_load,
    input  logic [8*NBYTES-1:0] score_in,
    output logic [8*NBYTES-1:0] score_out,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [7:0]          fb_addr,
    output logic [7:0]          fb_data,
    output logic                fb_dir,
    output logic                fb_start,
    input  logic                fb_done,
    input  logic [7:0]          fb_rdata
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, FINISH} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       tmo_cnt;
    logic [8*NBYTES-1:0] save_buf;
    logic [8*NBYTES-1:0] shadow;
    logic                accept;
    logic                timeout_hit;
    logic                last_byte;

    assign accept      = (state == IDLE) && (cmd_save || cmd_load);
    assign timeout_hit = (tmo_cnt == CW'(TIMEOUT - 1));
    assign last_byte   = (idx == IW'(NBYTES - 1));

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                // a done landing on the timeout cycle still counts as success
                if (fb_done)          state_nxt = GAP;
                else if (timeout_hit) state_nxt = IDLE;
            end
            GAP:     state_nxt = last_byte ? FINISH : ISSUE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            score_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            fb_addr   <= BASE_ADDR;
            fb_data   <= 8'h00;
            fb_dir    <= 1'b1;
            fb_start  <= 1'b0;
            idx       <= '0;
            tmo_cnt   <= '0;
            save_buf  <= '0;
            shadow    <= '0;
        end else begin
            fb_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        save_buf <= score_in;
                        idx      <= '0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        fb_dir   <= ~cmd_save;
                    end
                end
                ISSUE: begin
                    fb_addr  <= BASE_ADDR + 8'(idx);
                    fb_data  <= save_buf[8*idx +: 8];
                    fb_start <= 1'b1;
                    tmo_cnt  <= '0;
                end
                WAIT: begin
                    if (fb_done) begin
                        if (fb_dir) shadow[8*idx +: 8] <= fb_rdata;
                    end else if (timeout_hit) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                GAP: begin
                    // done is visible during FINISH; the loaded record lands one cycle later
                    if (last_byte) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FINISH: begin
                    if (fb_dir) score_out <= shadow;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_score_seq.sv
// tb/tb_flash_score_seq.sv - randomized self-checking bench for flash_score_seq against a bridge model
module tb_flash_score_seq;

    logic        CLK_50MHZ = 1'b0;
    logic        RST;
    logic        cmd_save;
    logic        cmd_load;
    logic [31:0] score_in;

    logic [31:0] score_out_v [2];
    logic        busy_v      [2];
    logic        done_v      [2];
    logic        err_v       [2];
    logic [7:0]  fb_addr_v   [2];
    logic [7:0]  fb_data_v   [2];
    logic        fb_dir_v    [2];
    logic        fb_start_v  [2];
    logic        fb_done_v   [2];
    logic [7:0]  fb_rdata_v  [2];

    logic [7:0]  base_of [2] = '{8'h00, 8'hFE};

    int n_checks = 0;
    int n_fail   = 0;

    always #10 CLK_50MHZ = ~CLK_50MHZ;

    flash_score_seq #(.NBYTES(4), .BASE_ADDR(8'h00), .TIMEOUT(16)) u_dut (
        .CLK_50MHZ(CLK_50MHZ), .RST(RST), .cmd_save(cmd_save), .cmd_load(cmd_load),
        .score_in(score_in), .score_out(score_out_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .err(err_v[0]), .fb_addr(fb_addr_v[0]), .fb_data(fb_data_v[0]), .fb_dir(fb_dir_v[0]),
        .fb_start(fb_start_v[0]), .fb_done(fb_done_v[0]), .fb_rdata(fb_rdata_v[0])
    );

    flash_score_seq #(.NBYTES(4), .BASE_ADDR(8'hFE), .TIMEOUT(16)) u_wrap (
        .CLK_50MHZ(CLK_50MHZ), .RST(RST), .cmd_save(cmd_save), .cmd_load(cmd_load),
        .score_in(score_in), .score_out(score_out_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .err(err_v[1]), .fb_addr(fb_addr_v[1]), .fb_data(fb_data_v[1]), .fb_dir(fb_dir_v[1]),
        .fb_start(fb_start_v[1]), .fb_done(fb_done_v[1]), .fb_rdata(fb_rdata_v[1])
    );

    // Bridge model: done (with read data) 3 cycles after the start cycle; start number hang_at never answers
    logic [7:0] mem [2][256];
    int         nstart  [2] = '{0, 0};
    int         hang_at [2] = '{-1, -1};
    logic       pend    [2];
    logic [1:0] dly     [2];

    always @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 2; k++) begin
                fb_done_v[k] <= 1'b0;
                pend[k]      <= 1'b0;
                dly[k]       <= 2'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                fb_done_v[k] <= 1'b0;
                if (fb_start_v[k]) begin
                    nstart[k] <= nstart[k] + 1;
                    pend[k]   <= (nstart[k] + 1 != hang_at[k]);
                    dly[k]    <= 2'd1;
                end else if (pend[k]) begin
                    if (dly[k] == 2'd0) begin
                        fb_done_v[k]  <= 1'b1;
                        fb_rdata_v[k] <= mem[k][fb_addr_v[k]];
                        pend[k]       <= 1'b0;
                    end else begin
                        dly[k] <= dly[k] - 2'd1;
                    end
                end
            end
        end
    end

    // Observed bridge transactions {addr, data, dir} and activity counters
    logic [16:0] txq0 [$];
    logic [16:0] txq1 [$];
    int   busy_cnt [2] = '{0, 0};
    int   done_cnt [2] = '{0, 0};
    int   wide_cnt [2] = '{0, 0};
    logic prev_start [2] = '{1'b0, 1'b0};

    always @(negedge CLK_50MHZ) begin
        for (int k = 0; k < 2; k++) begin
            if (fb_start_v[k] && prev_start[k]) wide_cnt[k]++;
            prev_start[k] = fb_start_v[k];
            if (busy_v[k]) busy_cnt[k]++;
            if (done_v[k]) done_cnt[k]++;
        end
        if (fb_start_v[0]) txq0.push_back({fb_addr_v[0], fb_data_v[0], fb_dir_v[0]});
        if (fb_start_v[1]) txq1.push_back({fb_addr_v[1], fb_data_v[1], fb_dir_v[1]});
    end

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (score_out_v[k] !== 32'h0) begin n_fail++; $display("FAIL reset_score_out%0d: got %h expected 0", k, score_out_v[k]); end
            n_checks++;
            if ({busy_v[k], done_v[k], err_v[k], fb_start_v[k], fb_dir_v[k]} !== 5'b00001) begin
                n_fail++; $display("FAIL reset_flags%0d: got busy/done/err/start/dir=%b expected 00001", k,
                                   {busy_v[k], done_v[k], err_v[k], fb_start_v[k], fb_dir_v[k]});
            end
            n_checks++;
            if (fb_addr_v[k] !== base_of[k]) begin n_fail++; $display("FAIL reset_fb_addr%0d: got %h expected %h", k, fb_addr_v[k], base_of[k]); end
            n_checks++;
            if (fb_data_v[k] !== 8'h00) begin n_fail++; $display("FAIL reset_fb_data%0d: got %h expected 00", k, fb_data_v[k]); end
        end
    endtask

    task automatic test_save(input logic [31:0] val);
        int n0, b0, d0, w0;
        bit ok;
        logic [16:0] exp, got;
        n0 = txq0.size(); b0 = busy_cnt[0]; d0 = done_cnt[0]; w0 = wide_cnt[0];
        score_in = val; cmd_save = 1'b1;
        @(negedge CLK_50MHZ);
        cmd_save = 1'b0; score_in = $urandom;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge CLK_50MHZ);
            if (done_v[0]) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL save_done: got no done within 200 cycles expected one"); end
        repeat (2) @(negedge CLK_50MHZ);
        n_checks++;
        if (txq0.size() - n0 != 4) begin n_fail++; $display("FAIL save_starts: got %0d expected 4", txq0.size() - n0); end
        for (int i = 0; i < 4; i++) begin
            exp = {8'(i), val[8*i +: 8], 1'b0};
            got = (n0 + i < txq0.size()) ? txq0[n0 + i] : 17'h0;
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL save_txn%0d: got %h expected %h", i, got, exp); end
        end
        n_checks++;
        if (busy_cnt[0] - b0 != 24) begin n_fail++; $display("FAIL save_busy_cycles: got %0d expected 24", busy_cnt[0] - b0); end
        n_checks++;
        if (done_cnt[0] - d0 != 1) begin n_fail++; $display("FAIL save_done_count: got %0d expected 1", done_cnt[0] - d0); end
        n_checks++;
        if (wide_cnt[0] != w0) begin n_fail++; $display("FAIL save_start_width: got %0d wide starts expected 0", wide_cnt[0] - w0); end
    endtask

    task automatic test_load(input bit fixed);
        logic [31:0] old, expv, snap;
        logic [16:0] exp, got;
        int n0, held_bad;
        bit ok;
        for (int a = 0; a < 4; a++) mem[0][a] = fixed ? 8'(17 * (a + 1)) : 8'($urandom);
        expv = {mem[0][3], mem[0][2], mem[0][1], mem[0][0]};
        n0 = txq0.size();
        snap = $urandom; score_in = snap; old = score_out_v[0];
        cmd_load = 1'b1;
        @(negedge CLK_50MHZ);
        cmd_load = 1'b0;
        held_bad = 0; ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge CLK_50MHZ);
            if (done_v[0]) ok = 1'b1;
            else if (score_out_v[0] !== old) held_bad++;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL load_done: got no done within 200 cycles expected one"); end
        n_checks++;
        if (held_bad != 0) begin n_fail++; $display("FAIL load_held: got %0d early changes expected 0", held_bad); end
        n_checks++;
        if (score_out_v[0] !== old) begin n_fail++; $display("FAIL load_finish_cycle: got %h expected %h", score_out_v[0], old); end
        @(negedge CLK_50MHZ);
        n_checks++;
        if (score_out_v[0] !== expv) begin n_fail++; $display("FAIL load_score_out: got %h expected %h", score_out_v[0], expv); end
        for (int i = 0; i < 4; i++) begin
            exp = {8'(i), snap[8*i +: 8], 1'b1};
            got = (n0 + i < txq0.size()) ? txq0[n0 + i] : 17'h0;
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL load_txn%0d: got %h expected %h", i, got, exp); end
        end
        repeat (2) @(negedge CLK_50MHZ);
    endtask

    task automatic test_timeout;
        logic [31:0] old;
        int d0, starts, s, e;
        bit ok;
        old = score_out_v[0]; d0 = done_cnt[0];
        for (int a = 0; a < 4; a++) mem[0][a] = 8'($urandom);
        hang_at[0] = nstart[0] + 2;
        cmd_load = 1'b1;
        @(negedge CLK_50MHZ);
        cmd_load = 1'b0;
        starts = 0; s = -1; e = -1; ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge CLK_50MHZ);
            if (fb_start_v[0]) begin
                starts++;
                if (starts == 2) s = t;
            end
            if (err_v[0]) begin e = t; ok = 1'b1; end
        end
        n_checks++;
        if (!ok || e - s != 16) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles expected 16", e - s); end
        n_checks++;
        if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", busy_v[0]); end
        hang_at[0] = -1;
        repeat (40) @(negedge CLK_50MHZ);
        n_checks++;
        if (done_cnt[0] != d0) begin n_fail++; $display("FAIL timeout_no_done: got %0d done pulses expected 0", done_cnt[0] - d0); end
        n_checks++;
        if (score_out_v[0] !== old) begin n_fail++; $display("FAIL timeout_score_out: got %h expected %h", score_out_v[0], old); end
        n_checks++;
        if (err_v[0] !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b expected 1", err_v[0]); end
        cmd_load = 1'b1;
        @(negedge CLK_50MHZ);
        cmd_load = 1'b0;
        n_checks++;
        if ({err_v[0], busy_v[0]} !== 2'b01) begin n_fail++; $display("FAIL timeout_err_clear: got err/busy=%b expected 01", {err_v[0], busy_v[0]}); end
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge CLK_50MHZ);
            if (done_v[0]) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL timeout_retry_done: got no done expected one"); end
        repeat (3) @(negedge CLK_50MHZ);
    endtask

    task automatic test_both(input logic [31:0] val);
        int n0, d0, bad;
        n0 = txq0.size(); d0 = done_cnt[0];
        score_in = val; cmd_save = 1'b1; cmd_load = 1'b1;
        @(negedge CLK_50MHZ);
        cmd_save = 1'b0; cmd_load = 1'b0;
        repeat (8) @(negedge CLK_50MHZ);
        cmd_load = 1'b1;
        @(negedge CLK_50MHZ);
        cmd_load = 1'b0;
        repeat (40) @(negedge CLK_50MHZ);
        n_checks++;
        if (txq0.size() - n0 != 4) begin n_fail++; $display("FAIL both_starts: got %0d expected 4", txq0.size() - n0); end
        bad = 0;
        for (int i = 0; i < 4 && n0 + i < txq0.size(); i++)
            if (txq0[n0 + i] !== {8'(i), val[8*i +: 8], 1'b0}) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL both_save_txns: got %0d wrong transactions expected 0", bad); end
        n_checks++;
        if (done_cnt[0] - d0 != 1) begin n_fail++; $display("FAIL both_done_count: got %0d expected 1", done_cnt[0] - d0); end
    endtask

    task automatic test_wrap(input logic [31:0] val);
        int n1;
        bit ok;
        logic [7:0] a;
        logic [16:0] exp, got;
        n1 = txq1.size();
        score_in = val; cmd_save = 1'b1;
        @(negedge CLK_50MHZ);
        cmd_save = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge CLK_50MHZ);
            if (done_v[1]) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wrap_done: got no done expected one"); end
        repeat (2) @(negedge CLK_50MHZ);
        a = 8'hFE;
        for (int i = 0; i < 4; i++) begin
            exp = {a, val[8*i +: 8], 1'b0};
            got = (n1 + i < txq1.size()) ? txq1[n1 + i] : 17'h0;
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL wrap_txn%0d: got %h expected %h", i, got, exp); end
            a = a + 8'd1;
        end
    endtask

    task automatic test_back_to_back(input logic [31:0] val);
        int n0, d0, t1, t2, nd;
        n0 = txq0.size(); d0 = done_cnt[0];
        score_in = val; cmd_save = 1'b1;
        t1 = -1; t2 = -1; nd = 0;
        for (int t = 0; t < 200 && nd < 2; t++) begin
            @(negedge CLK_50MHZ);
            if (done_v[0]) begin
                nd++;
                if (nd == 1) t1 = t; else t2 = t;
            end
        end
        cmd_save = 1'b0;
        n_checks++;
        if (nd != 2 || t2 - t1 != 26) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles expected 26", t2 - t1); end
        repeat (30) @(negedge CLK_50MHZ);
        n_checks++;
        if (txq0.size() - n0 != 8) begin n_fail++; $display("FAIL b2b_starts: got %0d expected 8", txq0.size() - n0); end
        n_checks++;
        if (done_cnt[0] - d0 != 2 || busy_v[0] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_done_count: got %0d dones busy=%b expected 2 dones busy=0", done_cnt[0] - d0, busy_v[0]);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] expv;
        int starts;
        bit ok;
        mem[0][0] = 8'h5A;
        for (int a = 1; a < 4; a++) mem[0][a] = 8'($urandom);
        expv = {mem[0][3], mem[0][2], mem[0][1], mem[0][0]};
        cmd_load = 1'b1;
        @(negedge CLK_50MHZ);
        cmd_load = 1'b0;
        repeat (30) @(negedge CLK_50MHZ);
        n_checks++;
        if (score_out_v[0] !== expv) begin n_fail++; $display("FAIL rmid_preload: got %h expected %h", score_out_v[0], expv); end
        cmd_load = 1'b1;
        @(negedge CLK_50MHZ);
        cmd_load = 1'b0;
        starts = 0; ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge CLK_50MHZ);
            if (fb_start_v[0]) starts++;
            if (starts == 3) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rmid_third_start: got %0d starts expected 3", starts); end
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if (score_out_v[0] !== 32'h0) begin n_fail++; $display("FAIL rmid_score_out: got %h expected 0", score_out_v[0]); end
        n_checks++;
        if ({busy_v[0], done_v[0], err_v[0], fb_start_v[0], fb_dir_v[0]} !== 5'b00001) begin
            n_fail++; $display("FAIL rmid_flags: got busy/done/err/start/dir=%b expected 00001",
                               {busy_v[0], done_v[0], err_v[0], fb_start_v[0], fb_dir_v[0]});
        end
        n_checks++;
        if ({fb_addr_v[0], fb_data_v[0]} !== 16'h0000) begin n_fail++; $display("FAIL rmid_fb_bus: got %h expected 0000", {fb_addr_v[0], fb_data_v[0]}); end
        repeat (2) @(negedge CLK_50MHZ);
        RST = 1'b0;
        repeat (3) @(negedge CLK_50MHZ);
        n_checks++;
        if (score_out_v[0] !== 32'h0) begin n_fail++; $display("FAIL rmid_no_partial: got %h expected 0", score_out_v[0]); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500 us");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; cmd_save = 1'b0; cmd_load = 1'b0; score_in = 32'h0;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) mem[k][a] = 8'($urandom);
        repeat (3) @(negedge CLK_50MHZ);
        test_reset;
        RST = 1'b0;
        repeat (2) @(negedge CLK_50MHZ);
        test_save(32'hA1B2C3D4);
        test_save($urandom);
        test_load(1'b1);
        test_load(1'b0);
        test_timeout;
        test_both($urandom);
        test_wrap($urandom);
        test_back_to_back($urandom);
        test_reset_mid;
        test_save($urandom);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_score_seq.md
Name: flash_score_seq

Overview:
- Upstream sequencer for the flash bridge; moves a multi-byte scoreboard record between score registers and flash, one byte per bridge transaction.
- Drives the bridge's addr/data/direction/start lines and consumes its one-cycle done pulse.
- Sits between the scoreboard control logic (save/load commands) and the flash bridge.

Parameters:
- NBYTES, 4, number of bytes in one record (1..16).
- BASE_ADDR, 8'h00, flash byte address of record byte 0.
- TIMEOUT, 1024, cycles to wait for fb_done per byte before aborting.

Ports:
- CLK_50MHZ  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- cmd_save  in  1  pulse or level; request to write the record to flash.
- cmd_load  in  1  pulse or level; request to read the record from flash.
- score_in  in  8*NBYTES  live score record; byte i is score_in[8i+7:8i].
- score_out  out  8*NBYTES  last successfully loaded record.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky timeout flag; cleared when the next command is accepted.
- fb_addr  out  8  byte address to the bridge.
- fb_data  out  8  write data to the bridge.
- fb_dir  out  1  1 = read, 0 = write (bridge direction_rw).
- fb_start  out  1  one-cycle start pulse to the bridge.
- fb_done  in  1  one-cycle completion pulse from the bridge.
- fb_rdata  in  8  flash read data, valid in the fb_done cycle.

Behaviour:
- All outputs are registered.
- Reset values: score_out=0, busy=0, done=0, err=0, fb_addr=BASE_ADDR, fb_data=0, fb_dir=1, fb_start=0. The state machine returns to IDLE.
- States: IDLE, ISSUE, WAIT, GAP, FINISH.
- IDLE:
  - Samples the commands every cycle. cmd_save takes priority when both are high.
  - On accept: snapshot score_in into a save buffer, set byte index=0, clear err, set fb_dir (save→0, load→1), then go to ISSUE.
  - busy is high from the cycle after accept.
- ISSUE:
  - Present fb_addr=BASE_ADDR+index (mod 256) and fb_data=buffer byte[index].
  - Assert fb_start for exactly this one cycle. Clear the timeout counter. Go to WAIT.
  - fb_addr, fb_data and fb_dir stay stable from ISSUE until fb_done is seen.
- WAIT:
  - Increment the timeout counter each cycle.
  - On fb_done=1, for a load, write fb_rdata into shadow byte[index]. Then go to GAP.
  - If the counter reaches TIMEOUT-1 without fb_done: set err=1 and return to IDLE with busy=0. No done pulse. score_out is unchanged.
  - fb_done arriving in the same cycle as the timeout takes priority: the byte succeeds.
- GAP:
  - One idle cycle with fb_start=0, which lets the bridge return to its IDLE state.
  - If index==NBYTES-1 go to FINISH; otherwise increment index and go to ISSUE.
- FINISH:
  - For a load, copy the shadow buffer into score_out (all bytes update in one cycle).
  - Pulse done=1 for one cycle, then go to IDLE. busy drops in the same cycle done is high.
- Commands that arrive while busy are ignored, not queued.
- A level-held command restarts a new transfer on the first IDLE cycle after FINISH.
- fb_done while in IDLE, ISSUE or GAP is ignored.
- Asynchronous reset mid-transfer aborts immediately to the reset values. Partial loads never reach score_out.
- Minimum per-byte cost is 3 + bridge latency cycles. With the current bridge (done 3 cycles after start), one byte takes 6 cycles and NBYTES=4 takes 24 cycles accept-to-done.

Test Plan:
- Save, bridge model returning done 3 cycles after each start, score_in=32'hA1B2C3D4:
  - Four starts, each exactly one cycle wide, at addresses 00,01,02,03 with data D4,C3,B2,A1 and fb_dir=0.
  - done pulses once; busy is high 24 cycles.
- Load, model returning rdata 11,22,33,44 for addresses 00..03:
  - score_out is 32'h44332211 only in the FINISH+1 cycle, with its prior value held until then.
  - fb_dir=1 throughout.
- Timeout, TIMEOUT=16, model never asserts done on the 2nd byte:
  - err=1 and busy=0 at 16 cycles after the 2nd start. No done pulse; score_out unchanged.
  - The next cmd_load clears err.
- cmd_save and cmd_load high in the same cycle → save performed (fb_dir=0). A cmd_load pulse mid-transfer → ignored, no extra transfer.
- BASE_ADDR=8'hFE, NBYTES=4 → addresses FE,FF,00,01 (wrap).
- Assert RST during WAIT of byte 2 of a load → all outputs at reset values asynchronously; score_out=0. After release, a fresh save completes normally.
